// File: rtl/hazard_stall_ctrl_pkg.sv
// hazard_stall_ctrl_pkg: shared widths, instruction field positions, opcodes and the ID/EX record
package hazard_stall_ctrl_pkg;
   localparam int DW = 16;
   localparam int IW = 19;
   localparam int OP_MSB = 18;
   localparam int OP_LSB = 14;
   localparam int DST_MSB = 13;
   localparam int DST_LSB = 11;
   localparam int A_MSB = 10;
   localparam int A_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 5;
   typedef logic [IW-1:0] instr_t;
   typedef logic [4:0] opcode_t;
   typedef logic [2:0] reg_t;
   localparam opcode_t OP_LW = 5'b10000;
   localparam opcode_t OP_SW = 5'b10001;
   localparam instr_t NOP = '0;
   typedef struct packed {
      instr_t instr;
      logic [DW-1:0] reg_a;
      logic [DW-1:0] reg_b;
      logic alu_b_mux;
   } id_ex_t;
   localparam id_ex_t ID_EX_BUBBLE = '{instr: NOP, reg_a: '0, reg_b: '0, alu_b_mux: 1'b0};
   function automatic opcode_t op_of(instr_t i);
      return i[OP_MSB:OP_LSB];
   endfunction
   function automatic reg_t dst_of(instr_t i);
      return i[DST_MSB:DST_LSB];
   endfunction
   function automatic reg_t a_of(instr_t i);
      return i[A_MSB:A_LSB];
   endfunction
   function automatic reg_t b_of(instr_t i);
      return i[B_MSB:B_LSB];
   endfunction
endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// hazard_stall_ctrl_if: ID-stage inputs, ID/EX contents, front-end control and counters
interface hazard_stall_ctrl_if;
   import hazard_stall_ctrl_pkg::*;
   instr_t IF_ID_instruction;
   logic [DW-1:0] ID_reg_A;
   logic [DW-1:0] ID_reg_B;
   logic ID_alu_B_mux;
   logic branch_taken;
   instr_t ID_EX_instruction;
   logic [DW-1:0] ID_EX_reg_A;
   logic [DW-1:0] ID_EX_reg_B;
   logic ID_EX_alu_B_mux;
   logic pc_write;
   logic IF_ID_write;
   logic IF_ID_flush;
   logic [15:0] stall_cycles;
   logic [7:0] flush_count;
   modport master (
      output IF_ID_instruction, ID_reg_A, ID_reg_B, ID_alu_B_mux, branch_taken,
      input ID_EX_instruction, ID_EX_reg_A, ID_EX_reg_B, ID_EX_alu_B_mux,
      input pc_write, IF_ID_write, IF_ID_flush, stall_cycles, flush_count
   );
   modport slave (
      input IF_ID_instruction, ID_reg_A, ID_reg_B, ID_alu_B_mux, branch_taken,
      output ID_EX_instruction, ID_EX_reg_A, ID_EX_reg_B, ID_EX_alu_B_mux,
      output pc_write, IF_ID_write, IF_ID_flush, stall_cycles, flush_count
   );
endinterface

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// load_use_detect: flags a consumer that reads a register a still-pending load will write
module load_use_detect
   import hazard_stall_ctrl_pkg::*;
(
   input instr_t producer,
   input instr_t consumer,
   output logic match
);
   reg_t dst;
   logic b_used;
   logic unused_bits;
   assign dst = dst_of(producer);
   assign b_used = consumer[OP_MSB -: 2] == 2'b00;
   assign unused_bits = ^{producer[A_MSB:0], consumer[B_LSB-1:0]};
   assign match = op_of(producer) == OP_LW && dst != '0 &&
                  (dst == a_of(consumer) ||
                   (b_used && dst == b_of(consumer)) ||
                   (op_of(consumer) == OP_SW && dst == dst_of(consumer)));
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use stall and branch flush control for the ID/EX pipeline register
module hazard_stall_ctrl
   import hazard_stall_ctrl_pkg::*;
(
   input logic clk,
   input logic rst,
   hazard_stall_ctrl_if.slave bus
);
   id_ex_t id_ex;
   instr_t ex_mem_shadow;
   logic [15:0] stall_q;
   logic [7:0] flush_q;
   logic m_ex, m_mem, hazard, stall;
   load_use_detect u_ex (.producer(id_ex.instr), .consumer(bus.IF_ID_instruction), .match(m_ex));
   load_use_detect u_mem (.producer(ex_mem_shadow), .consumer(bus.IF_ID_instruction), .match(m_mem));
   // Front-end control reacts in the same cycle a hazard or taken branch is seen; branch wins
   always_comb begin
      hazard = m_ex | m_mem;
      stall = hazard & ~bus.branch_taken;
      bus.pc_write = ~stall;
      bus.IF_ID_write = ~stall;
      bus.IF_ID_flush = bus.branch_taken;
   end
   // ID/EX register, EX/MEM shadow and saturating counters; bubbles and flushes both insert NOP
   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex <= ID_EX_BUBBLE;
         ex_mem_shadow <= NOP;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         ex_mem_shadow <= id_ex.instr;
         id_ex <= (hazard | bus.branch_taken) ? ID_EX_BUBBLE :
                  '{instr: bus.IF_ID_instruction, reg_a: bus.ID_reg_A, reg_b: bus.ID_reg_B, alu_b_mux: bus.ID_alu_B_mux};
         stall_q <= (stall && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
         flush_q <= (bus.branch_taken && !(&flush_q)) ? flush_q + 1'b1 : flush_q;
      end
   end
   assign bus.ID_EX_instruction = id_ex.instr;
   assign bus.ID_EX_reg_A = id_ex.reg_a;
   assign bus.ID_EX_reg_B = id_ex.reg_b;
   assign bus.ID_EX_alu_B_mux = id_ex.alu_b_mux;
   assign bus.stall_cycles = stall_q;
   assign bus.flush_count = flush_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed load-use/branch scenarios checked against a reference scoreboard
module tb_hazard_stall_ctrl;
   import hazard_stall_ctrl_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   hazard_stall_ctrl_if bus();
   hazard_stall_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   typedef struct {
      instr_t i;
      logic [15:0] a;
      logic [15:0] b;
      logic m;
      logic [15:0] sc;
      logic [7:0] fc;
   } exp_t;
   exp_t q[$];
   int tests = 0;
   int fails = 0;
   int bub = 0;
   instr_t m_ex = NOP;
   instr_t m_sh = NOP;
   logic [15:0] m_a = '0;
   logic [15:0] m_b = '0;
   logic m_m = 1'b0;
   logic [15:0] m_sc = '0;
   logic [7:0] m_fc = '0;

   function automatic instr_t mk(input logic [4:0] op, input logic [2:0] d, input logic [2:0] a, input logic [2:0] b);
      return {op, d, a, b, 5'b0};
   endfunction

   function automatic logic lu(input instr_t p, input instr_t c);
      if (p[18:14] != 5'b10000 || p[13:11] == 3'd0) return 1'b0;
      if (c[10:8] == p[13:11]) return 1'b1;
      if (c[18:17] == 2'b00 && c[7:5] == p[13:11]) return 1'b1;
      if (c[18:14] == 5'b10001 && c[13:11] == p[13:11]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input instr_t ins, input logic bt, input logic r);
      exp_t e;
      logic haz, stl;
      logic [15:0] a, b;
      logic m;
      a = 16'($urandom);
      b = 16'($urandom);
      m = 1'($urandom);
      @(negedge clk);
      rst = r;
      bus.IF_ID_instruction = ins;
      bus.ID_reg_A = a;
      bus.ID_reg_B = b;
      bus.ID_alu_B_mux = m;
      bus.branch_taken = bt;
      #1;
      if (r) begin
         m_ex = NOP; m_sh = NOP; m_a = '0; m_b = '0; m_m = 1'b0; m_sc = '0; m_fc = '0;
      end else begin
         haz = lu(m_ex, ins) | lu(m_sh, ins);
         stl = haz & ~bt;
         chk("pc_write", bus.pc_write, !stl);
         chk("IF_ID_write", bus.IF_ID_write, !stl);
         chk("IF_ID_flush", bus.IF_ID_flush, bt);
         if (bus.pc_write === 1'b0) bub++;
         m_sh = m_ex;
         if (haz | bt) begin
            m_ex = NOP; m_a = '0; m_b = '0; m_m = 1'b0;
         end else begin
            m_ex = ins; m_a = a; m_b = b; m_m = m;
         end
         if (stl && m_sc != 16'hFFFF) m_sc++;
         if (bt && m_fc != 8'hFF) m_fc++;
      end
      q.push_back('{m_ex, m_a, m_b, m_m, m_sc, m_fc});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("ID_EX_instruction", bus.ID_EX_instruction, e.i);
      chk("ID_EX_reg_A", bus.ID_EX_reg_A, e.a);
      chk("ID_EX_reg_B", bus.ID_EX_reg_B, e.b);
      chk("ID_EX_alu_B_mux", bus.ID_EX_alu_B_mux, e.m);
      chk("stall_cycles", bus.stall_cycles, e.sc);
      chk("flush_count", bus.flush_count, e.fc);
   endtask

   initial begin
      bus.IF_ID_instruction = NOP;
      bus.ID_reg_A = '0;
      bus.ID_reg_B = '0;
      bus.ID_alu_B_mux = 1'b0;
      bus.branch_taken = 1'b0;
      step(NOP, 1'b0, 1'b1);
      step(NOP, 1'b0, 1'b1);
      chk("rst_id_ex", bus.ID_EX_instruction, NOP);
      chk("rst_stall_cycles", bus.stall_cycles, 0);
      step(NOP, 1'b0, 1'b0);
      // LW $r2 then ADD $r3,$r2,$r1 back-to-back
      bub = 0;
      step(mk(OP_LW, 3'd2, 3'd1, 3'd0), 1'b0, 1'b0);
      repeat (3) step(mk(5'b00001, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0);
      chk("lw_adjacent_bubbles", bub, 2);
      chk("lw_adjacent_stall_cycles", bus.stall_cycles, 2);
      // LW $r2, unrelated, ADD with $r2 as B
      bub = 0;
      step(mk(OP_LW, 3'd2, 3'd1, 3'd0), 1'b0, 1'b0);
      step(mk(5'b00010, 3'd5, 3'd6, 3'd7), 1'b0, 1'b0);
      repeat (2) step(mk(5'b00001, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0);
      chk("lw_two_ahead_bubbles", bub, 1);
      // ADDI with $r2 only in the unused B field
      bub = 0;
      step(mk(OP_LW, 3'd2, 3'd1, 3'd0), 1'b0, 1'b0);
      step(NOP, 1'b0, 1'b0);
      step(mk(5'b01000, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0);
      step(mk(OP_LW, 3'd2, 3'd1, 3'd0), 1'b0, 1'b0);
      step(mk(5'b01000, 3'd3, 3'd1, 3'd2), 1'b0, 1'b0);
      chk("addi_b_bubbles", bub, 0);
      // LW $r0 never stalls
      bub = 0;
      step(mk(OP_LW, 3'd0, 3'd1, 3'd0), 1'b0, 1'b0);
      step(mk(5'b00001, 3'd3, 3'd0, 3'd0), 1'b0, 1'b0);
      chk("lw_r0_bubbles", bub, 0);
      chk("lw_r0_stall_cycles", bus.stall_cycles, 3);
      // hazard and branch_taken in the same cycle
      step(mk(OP_LW, 3'd2, 3'd1, 3'd0), 1'b0, 1'b0);
      step(mk(5'b00001, 3'd3, 3'd2, 3'd1), 1'b1, 1'b0);
      chk("branch_flush_count", bus.flush_count, 1);
      chk("branch_stall_cycles", bus.stall_cycles, 3);
      chk("branch_id_ex_nop", bus.ID_EX_instruction, NOP);
      step(NOP, 1'b0, 1'b0);
      step(NOP, 1'b0, 1'b0);
      // LW $r4 then SW $r4,($r1) with the stall counter near saturation
      @(negedge clk);
      force dut.stall_q = 16'hFFFE;
      #1;
      release dut.stall_q;
      m_sc = 16'hFFFE;
      bub = 0;
      step(mk(OP_LW, 3'd4, 3'd1, 3'd0), 1'b0, 1'b0);
      repeat (3) step(mk(OP_SW, 3'd4, 3'd1, 3'd0), 1'b0, 1'b0);
      chk("sw_dst_bubbles", bub, 2);
      chk("stall_saturated", bus.stall_cycles, 16'hFFFF);
      // reset during the second bubble
      step(mk(OP_LW, 3'd2, 3'd1, 3'd0), 1'b0, 1'b0);
      step(mk(5'b00001, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0);
      step(mk(5'b00001, 3'd3, 3'd2, 3'd1), 1'b0, 1'b1);
      chk("midstall_rst_id_ex", bus.ID_EX_instruction, NOP);
      chk("midstall_rst_stall_cycles", bus.stall_cycles, 0);
      chk("midstall_rst_flush_count", bus.flush_count, 0);
      bub = 0;
      step(mk(5'b00001, 3'd3, 3'd2, 3'd1), 1'b0, 1'b0);
      chk("post_rst_bubbles", bub, 0);
      // flush counter saturation
      repeat (257) step(NOP, 1'b1, 1'b0);
      chk("flush_saturated", bus.flush_count, 8'hFF);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
